// File: rtl/inst_cache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Address split, refill FSM states, and the storage dimensions.
package inst_cache_pkg;

    localparam int INDEX_BITS  = 6;
    localparam int OFFSET_BITS = 2;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int WORD_BITS   = INDEX_BITS + OFFSET_BITS;

    typedef logic [INDEX_BITS-1:0]  index_t;
    typedef logic [OFFSET_BITS-1:0] offset_t;
    typedef logic [TAG_BITS-1:0]    tag_t;
    typedef logic [ADDR_W-1:0]      addr_t;
    typedef logic [DATA_W-1:0]      data_t;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_REFILL = 2'd1,
        IC_DONE   = 2'd2
    } ic_state_t;

    typedef struct packed {
        tag_t       tag;
        index_t     index;
        offset_t    offset;
        logic [1:0] byte_off;
    } fetch_addr_t;

    function automatic fetch_addr_t split_addr(input addr_t a);
        return fetch_addr_t'(a);
    endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-port and refill-bus bundle of the instruction cache.
// slave = cache side; master = pc_reg/if_id/memory side.
interface inst_cache_if;
    import inst_cache_pkg::*;

    logic  rom_ce_i;
    addr_t rom_addr_i;
    data_t rom_data_o;
    logic  stallreq_o;
    logic  flush_i;
    logic  mem_req_o;
    addr_t mem_addr_o;
    logic  mem_ack_i;
    data_t mem_data_i;

    modport slave (
        input  rom_ce_i, rom_addr_i, flush_i,
        input  mem_ack_i, mem_data_i,
        output rom_data_o, stallreq_o,
        output mem_req_o, mem_addr_o
    );

    modport master (
        output rom_ce_i, rom_addr_i, flush_i,
        output mem_ack_i, mem_data_i,
        input  rom_data_o, stallreq_o,
        input  mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/inst_cache_ram.sv
// Word array for the cache data store: one synchronous write port,
// one asynchronous read port. Ports: clk, we_i/waddr_i/wdata_i, raddr_i/rdata_o.
module inst_cache_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [1<<AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with one-line refill on miss.
// Ports: clk, rst (sync, active high), bus (fetch port + refill req/ack bus).
module inst_cache (
    input logic         clk,
    input logic         rst,
    inst_cache_if.slave bus
);
    import inst_cache_pkg::*;

    ic_state_t        state_q, state_d;
    offset_t          cnt_q, cnt_d;
    tag_t             rtag_q, rtag_d;
    index_t           ridx_q, ridx_d;
    logic             flushed_q, flushed_d;
    logic [LINES-1:0] valid_q, valid_d;
    tag_t             tag_q [LINES];

    fetch_addr_t          fa;
    logic                 tag_hit;
    logic                 hit;
    logic                 miss;
    logic                 start_refill;
    logic                 ram_we;
    logic [WORD_BITS-1:0] ram_waddr;
    logic [WORD_BITS-1:0] ram_raddr;
    data_t                ram_rdata;
    logic                 unused_bits;

    assign fa          = split_addr(bus.rom_addr_i);
    assign unused_bits = ^fa.byte_off;

    assign tag_hit = valid_q[fa.index] && (tag_q[fa.index] == fa.tag);
    assign hit     = bus.rom_ce_i && (state_q == IC_IDLE) && tag_hit;
    assign miss    = bus.rom_ce_i && (state_q == IC_IDLE) && !tag_hit;

    // A flush in the same cycle as a miss wins; the miss retries next cycle.
    assign start_refill = miss && !bus.flush_i;

    assign ram_raddr = {fa.index, fa.offset};
    assign ram_waddr = {ridx_q, cnt_q};
    assign ram_we    = (state_q == IC_REFILL) && bus.mem_ack_i;

    assign bus.rom_data_o = hit ? ram_rdata : '0;

    inst_cache_ram #(
        .AW (WORD_BITS),
        .DW (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (bus.mem_data_i),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rtag_d         = rtag_q;
        ridx_d         = ridx_q;
        flushed_d      = flushed_q;
        valid_d        = valid_q;
        bus.stallreq_o = 1'b0;
        bus.mem_req_o  = 1'b0;
        bus.mem_addr_o = '0;

        unique case (state_q)
            IC_IDLE: begin
                bus.stallreq_o = miss;
                if (start_refill) begin
                    state_d          = IC_REFILL;
                    rtag_d           = fa.tag;
                    ridx_d           = fa.index;
                    cnt_d            = '0;
                    valid_d[fa.index] = 1'b0;
                end
            end
            IC_REFILL: begin
                bus.stallreq_o = 1'b1;
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = {rtag_q, ridx_q, cnt_q, 2'b00};
                if (bus.flush_i) begin
                    flushed_d = 1'b1;
                end
                if (bus.mem_ack_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = IC_DONE;
                        // A flush anywhere in the refill leaves the line invalid.
                        if (!flushed_q && !bus.flush_i) begin
                            valid_d[ridx_q] = 1'b1;
                        end
                    end
                end
            end
            IC_DONE: begin
                bus.stallreq_o = 1'b1;
                state_d        = IC_IDLE;
                flushed_d      = 1'b0;
            end
            default: begin
                state_d = IC_IDLE;
            end
        endcase

        if (bus.flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IC_IDLE;
            cnt_q     <= '0;
            rtag_q    <= '0;
            ridx_q    <= '0;
            flushed_q <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rtag_q    <= rtag_d;
            ridx_q    <= ridx_d;
            flushed_q <= flushed_d;
            valid_q   <= valid_d;
        end
    end

    // Tag store is not reset; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (start_refill) begin
            tag_q[fa.index] <= fa.tag;
        end
    end

endmodule
